// File: rtl/mem_arb_pkg.sv
// Shared definitions for the unified memory arbiter: FSM state encoding and
// the word order used for two-word (PC / SP) transfers.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WIDE = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  // Low word lives at the base address, high word at base + 1.
  localparam int unsigned LO_OFS = 0;
  localparam int unsigned HI_OFS = 1;

endpackage

// File: rtl/starve_counter.sv
// Saturating fetch-starvation counter.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   clr         : clear (fetch granted), wins over inc
//   inc         : count one denied fetch cycle
//   starved_c   : count has reached MAX (combinational from the register)
module starve_counter #(
  parameter int unsigned MAX   = 4,
  parameter int unsigned CNT_W = $clog2(MAX + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic starved_c
);

  logic [CNT_W-1:0] count_q;

  // Count denied cycles, hold at MAX until a fetch is granted.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (inc && (count_q != CNT_W'(MAX))) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  assign starved_c = (count_q == CNT_W'(MAX));

endmodule

// File: rtl/unified_mem_arbiter.sv
// Shares one single-port, synchronous-read memory between instruction fetch
// and the memory stage. Data accesses win unless fetch has been starved for
// STARVE_MAX cycles; two-word transfers take an extra WIDE cycle.
// Ports:
//   clk, reset                    : clock, synchronous active-high reset
//   if_req/if_addr                : fetch request and word address
//   if_gnt                        : fetch issued this cycle (combinational)
//   if_valid/if_rdata             : fetched word, one cycle after if_gnt
//   dm_req/dm_rw/dm_wide/dm_addr/dm_wdata : held data request
//   dm_rdata/dm_done              : read data and one-cycle completion pulse
//   dm_stall                      : pipeline freeze while a data access is pending
//   mem_en/mem_rw/mem_addr/mem_wdata/mem_rdata : memory macro port
module unified_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = 12,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_valid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                dm_req,
  input  logic                dm_rw,
  input  logic                dm_wide,
  input  logic [ADDR_W-1:0]   dm_addr,
  input  logic [2*DATA_W-1:0] dm_wdata,
  output logic [2*DATA_W-1:0] dm_rdata,
  output logic                dm_done,
  output logic                dm_stall,
  output logic                mem_en,
  output logic                mem_rw,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata
);

  arb_state_e        state_q, state_d;
  logic              starved_c;
  logic              dm_issue_c;
  logic              op_wide_q;
  logic              if_valid_q;
  logic [DATA_W-1:0] lo_q;

  starve_counter #(
    .MAX   (STARVE_MAX),
    .CNT_W ($clog2(STARVE_MAX + 1))
  ) u_starve (
    .clk       (clk),
    .reset     (reset),
    .clr       (if_gnt),
    .inc       (if_req & ~if_gnt),
    .starved_c (starved_c)
  );

  // State register plus the small amount of registered response state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      if_valid_q <= 1'b0;
      op_wide_q  <= 1'b0;
      lo_q       <= '0;
    end else begin
      state_q    <= state_d;
      if_valid_q <= if_gnt;
      if (dm_issue_c) begin
        op_wide_q <= dm_wide;
      end
      // Word 0 of a wide access returns during WIDE; keep it for RESP.
      if (state_q == WIDE) begin
        lo_q <= mem_rdata;
      end
    end
  end

  // Next state and memory-port steering; nothing is issued while in reset.
  always_comb begin
    state_d    = state_q;
    if_gnt     = 1'b0;
    dm_issue_c = 1'b0;
    mem_en     = 1'b0;
    mem_rw     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    if (!reset) begin
      case (state_q)
        IDLE: begin
          if (dm_req && !starved_c) begin
            dm_issue_c = 1'b1;
            mem_en     = 1'b1;
            mem_rw     = dm_rw;
            mem_addr   = dm_addr + ADDR_W'(LO_OFS);
            mem_wdata  = dm_wdata[DATA_W-1:0];
            state_d    = dm_wide ? WIDE : RESP;
          end else if (if_req) begin
            if_gnt   = 1'b1;
            mem_en   = 1'b1;
            mem_addr = if_addr;
          end
        end
        WIDE: begin
          // Second word is never preempted, even when fetch is starved.
          mem_en    = 1'b1;
          mem_rw    = dm_rw;
          mem_addr  = dm_addr + ADDR_W'(HI_OFS);
          mem_wdata = dm_wdata[2*DATA_W-1:DATA_W];
          state_d   = RESP;
        end
        RESP: begin
          // Data request is not re-accepted here, so fetch gets the slot.
          state_d = IDLE;
          if (if_req) begin
            if_gnt   = 1'b1;
            mem_en   = 1'b1;
            mem_addr = if_addr;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  assign dm_done  = (state_q == RESP) & ~reset;
  assign dm_stall = dm_req & ~dm_done & ~reset;
  assign if_valid = if_valid_q;
  assign if_rdata = if_valid_q ? mem_rdata : '0;

  // Narrow reads take word 0 straight from memory; wide reads pair the
  // captured low word with the high word arriving now.
  assign dm_rdata = !dm_done  ? '0 :
                    op_wide_q ? {mem_rdata, lo_q} :
                                {{DATA_W{1'b0}}, mem_rdata};

endmodule
